// File: rtl/etype_pkg.sv
// Shared types for the ethertype CAM filter: CAM entry layout, per-packet
// FSM state encoding and the ethertype field size.
package etype_pkg;

  // Ethertype field width in bits (wire byte order, never swapped).
  localparam int ET_SIZE = 16;

  // Widest route mask an entry can carry (AXIS_ID_WIDTH up to 8). Instances
  // with fewer ids zero-fill the upper bits, which then fold away as constants.
  localparam int CAM_MAX_AXIS_ID = 256;

  // Per-packet classification state.
  typedef enum logic [0:0] {
    ST_WAIT_ETYPE = 1'b0,
    ST_HOLD       = 1'b1
  } etype_state_e;

  // One programmable CAM entry.
  typedef struct packed {
    logic [ET_SIZE-1:0]         etype;
    logic [CAM_MAX_AXIS_ID-1:0] allow;
    logic                       bypass_mac;
    logic                       valid;
  } cam_entry_t;

endpackage : etype_pkg

// File: rtl/etype_cam_match.sv
// Parallel ethertype compare across all CAM entries; the lowest-index valid
// match wins when several entries carry the same ethertype.
module etype_cam_match
  import etype_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = 2
) (
  input  cam_entry_t         entries_i [NUM_ENTRIES],
  input  logic [ET_SIZE-1:0] key_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_ENTRIES-1:0] match_vec;
  // Route fields are irrelevant to matching; folded here so they read as used.
  logic [NUM_ENTRIES-1:0] unused_entry_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
      assign match_vec[gi] = entries_i[gi].valid && (entries_i[gi].etype == key_i);
      assign unused_entry_bits[gi] = ^{entries_i[gi].allow, entries_i[gi].bypass_mac};
    end
  endgenerate

  // Priority encode: scanning from the top lets the lowest matching index win.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule : etype_cam_match

// File: rtl/etype_cam_filter.sv
// Ethertype CAM filter: classifies each packet by its parsed ethertype against
// a small programmable CAM and narrows the route mask accordingly. The AXIS
// stream and side channel pass straight through with no added latency.
// Optional build macro ETYPE_CAM_STATS_EN adds per-entry hit counters and a
// miss counter with a read port.
module etype_cam_filter
  import etype_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int AXIS_DEST_WIDTH   = 4,
  parameter int MAX_PACKET_LENGTH = 1522,
  parameter int NUM_ENTRIES       = 4,
  localparam int NUM_AXIS_ID         = 2 ** AXIS_ID_WIDTH,
  localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 1),
  localparam int IDX_W               = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int ID_W                = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int DEST_W              = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int KEEP_W              = AXIS_BUS_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // AXIS in
  input  logic [AXIS_BUS_WIDTH-1:0]      axis_in_tdata,
  input  logic [ID_W-1:0]                axis_in_tid,
  input  logic [DEST_W-1:0]              axis_in_tdest,
  input  logic [KEEP_W-1:0]              axis_in_tkeep,
  input  logic                           axis_in_tlast,
  input  logic                           axis_in_tvalid,
  output logic                           axis_in_tready,
  // AXIS out
  output logic [AXIS_BUS_WIDTH-1:0]      axis_out_tdata,
  output logic [ID_W-1:0]                axis_out_tid,
  output logic [DEST_W-1:0]              axis_out_tdest,
  output logic [KEEP_W-1:0]              axis_out_tkeep,
  output logic                           axis_out_tlast,
  output logic                           axis_out_tvalid,
  input  logic                           axis_out_tready,
  // Side channel in
  input  logic [NUM_AXIS_ID-1:0]         route_mask_mac_in,
  input  logic [NUM_AXIS_ID-1:0]         route_mask_vlan_in,
  input  logic                           parsing_done_in,
  input  logic [PACKET_LENGTH_CBITS-1:0] cur_pos_in,
  input  logic                           is_tagged_in,
  input  logic [ET_SIZE-1:0]             parsed_etype,
  input  logic                           parsed_etype_valid,
  // Side channel out
  output logic [NUM_AXIS_ID-1:0]         route_mask_out,
  output logic                           parsing_done_out,
  output logic [PACKET_LENGTH_CBITS-1:0] cur_pos_out,
  output logic                           is_tagged_out,
  output logic                           etype_hit,
  output logic [IDX_W-1:0]               etype_hit_idx,
  // CAM programming
  input  logic                           cam_wr_en,
  input  logic [IDX_W-1:0]               cam_wr_idx,
  input  logic [ET_SIZE-1:0]             cam_wr_etype,
  input  logic [NUM_AXIS_ID-1:0]         cam_wr_allow,
  input  logic                           cam_wr_bypass_mac,
  input  logic                           cam_wr_valid,
  input  logic [NUM_AXIS_ID-1:0]         allow_all_mask
`ifdef ETYPE_CAM_STATS_EN
  ,
  input  logic [IDX_W-1:0]               stats_rd_idx,
  output logic [31:0]                    stats_rd_count,
  output logic [31:0]                    stats_miss_count
`endif
);

  // ---------------------------------------------------------------------------
  // Straight passthrough of stream and side channel
  // ---------------------------------------------------------------------------
  assign axis_out_tdata   = axis_in_tdata;
  assign axis_out_tid     = axis_in_tid;
  assign axis_out_tdest   = axis_in_tdest;
  assign axis_out_tkeep   = axis_in_tkeep;
  assign axis_out_tlast   = axis_in_tlast;
  assign axis_out_tvalid  = axis_in_tvalid;
  assign axis_in_tready   = axis_out_tready;
  assign parsing_done_out = parsing_done_in;
  assign cur_pos_out      = cur_pos_in;
  assign is_tagged_out    = is_tagged_in;

  // ---------------------------------------------------------------------------
  // CAM storage
  // ---------------------------------------------------------------------------
  cam_entry_t             entries_q [NUM_ENTRIES];
  cam_entry_t             cam_wr_entry;
  logic [NUM_ENTRIES-1:0] wr_sel;

  // Assemble the entry image to be written, zero-filling unused route bits.
  always_comb begin
    cam_wr_entry                             = '0;
    cam_wr_entry.etype                       = cam_wr_etype;
    cam_wr_entry.allow[NUM_AXIS_ID-1:0]      = cam_wr_allow;
    cam_wr_entry.bypass_mac                  = cam_wr_bypass_mac;
    cam_wr_entry.valid                       = cam_wr_valid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign wr_sel[gi] = cam_wr_en && (cam_wr_idx == IDX_W'(gi));

      // Entry register: writes land on the next edge, so a same-cycle compare
      // still sees the old contents.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          entries_q[gi] <= '0;
        end else if (wr_sel[gi]) begin
          entries_q[gi] <= cam_wr_entry;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Live compare
  // ---------------------------------------------------------------------------
  logic                   cur_hit;
  logic [IDX_W-1:0]       cur_idx;
  cam_entry_t             cur_entry;
  logic [NUM_AXIS_ID-1:0] cur_emask;
  logic                   cur_bypass;
  logic                   unused_cur_bits;

  etype_cam_match #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_match (
    .entries_i (entries_q),
    .key_i     (parsed_etype),
    .hit_o     (cur_hit),
    .idx_o     (cur_idx)
  );

  assign cur_entry       = entries_q[cur_idx];
  assign cur_emask       = allow_all_mask | (cur_hit ? cur_entry.allow[NUM_AXIS_ID-1:0] : '0);
  assign cur_bypass      = cur_hit & cur_entry.bypass_mac;
  assign unused_cur_bits = ^{cur_entry.etype, cur_entry.valid, cur_entry.allow >> NUM_AXIS_ID};

  // ---------------------------------------------------------------------------
  // Per-packet FSM
  // ---------------------------------------------------------------------------
  etype_state_e           state_q, state_d;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_AXIS_ID-1:0] emask_q, emask_d;
  logic                   bypass_q, bypass_d;

  logic                   last_beat;
  logic                   accept;
  logic [NUM_AXIS_ID-1:0] emask_sel;
  logic                   bypass_sel;

  assign last_beat = axis_in_tvalid & axis_out_tready & axis_in_tlast;
  // Reset is folded in so that outputs show the idle result while held in reset.
  assign accept    = aresetn & (state_q == ST_WAIT_ETYPE) & parsed_etype_valid;

  // State and latched classification registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_WAIT_ETYPE;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      emask_q  <= '1;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
      emask_q  <= emask_d;
      bypass_q <= bypass_d;
    end
  end

  // Next state and result selection: live compare on the accepted cycle,
  // latched copy while holding, neutral result otherwise.
  always_comb begin
    state_d       = state_q;
    hit_d         = hit_q;
    idx_d         = idx_q;
    emask_d       = emask_q;
    bypass_d      = bypass_q;
    etype_hit     = 1'b0;
    etype_hit_idx = '0;
    emask_sel     = '1;
    bypass_sel    = 1'b0;
    case (state_q)
      ST_WAIT_ETYPE: begin
        if (accept) begin
          etype_hit     = cur_hit;
          etype_hit_idx = cur_idx;
          emask_sel     = cur_emask;
          bypass_sel    = cur_bypass;
          if (!last_beat) begin
            state_d  = ST_HOLD;
            hit_d    = cur_hit;
            idx_d    = cur_idx;
            emask_d  = cur_emask;
            bypass_d = cur_bypass;
          end
        end
      end
      ST_HOLD: begin
        etype_hit     = hit_q;
        etype_hit_idx = idx_q;
        emask_sel     = emask_q;
        bypass_sel    = bypass_q;
        if (last_beat) begin
          state_d  = ST_WAIT_ETYPE;
          hit_d    = 1'b0;
          idx_d    = '0;
          emask_d  = '1;
          bypass_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_WAIT_ETYPE;
      end
    endcase
  end

  assign route_mask_out = emask_sel & route_mask_vlan_in &
                          (bypass_sel ? {NUM_AXIS_ID{1'b1}} : route_mask_mac_in);

`ifdef ETYPE_CAM_STATS_EN
  // ---------------------------------------------------------------------------
  // Hit / miss statistics
  // ---------------------------------------------------------------------------
  logic [31:0] stats_cnt_q [NUM_ENTRIES];
  logic [31:0] miss_cnt_q;

  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_stats
      // Saturating per-entry hit count; reprogramming the entry restarts it.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          stats_cnt_q[gi] <= '0;
        end else if (wr_sel[gi]) begin
          stats_cnt_q[gi] <= '0;
        end else if (accept && cur_hit && (cur_idx == IDX_W'(gi)) &&
                     (stats_cnt_q[gi] != 32'hFFFF_FFFF)) begin
          stats_cnt_q[gi] <= stats_cnt_q[gi] + 32'd1;
        end
      end
    end
  endgenerate

  // Saturating count of packets whose ethertype matched no entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      miss_cnt_q <= '0;
    end else if (accept && !cur_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Counter read mux; indices beyond the CAM read as zero.
  always_comb begin
    stats_rd_count = '0;
    if (int'(stats_rd_idx) < NUM_ENTRIES) begin
      stats_rd_count = stats_cnt_q[stats_rd_idx];
    end
  end

  assign stats_miss_count = miss_cnt_q;
`endif

endmodule : etype_cam_filter

// File: tb/tb_etype_cam_filter.sv
// Self-checking bench for etype_cam_filter: directed scenarios followed by
// randomized traffic, all checked against a behavioural packet-level model.
module tb_etype_cam_filter;

  localparam int N_ENT = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] in_tdata, out_tdata;
  logic [3:0]  in_tid, out_tid, in_tdest, out_tdest;
  logic [7:0]  in_tkeep, out_tkeep;
  logic        in_tlast, out_tlast, in_tvalid, out_tvalid, in_tready, out_tready;
  logic [15:0] mac, vlan, petype, route_out, allow_all;
  logic        pd_in, pd_out, tag_in, tag_out, pvalid, hit;
  logic [10:0] pos_in, pos_out;
  logic [1:0]  hit_idx;
  logic        wr_en, wr_byp, wr_valid;
  logic [1:0]  wr_idx;
  logic [15:0] wr_etype, wr_allow;
`ifdef ETYPE_CAM_STATS_EN
  logic [1:0]  st_idx;
  logic [31:0] st_cnt, st_miss;
`endif

  etype_cam_filter dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .axis_in_tdata      (in_tdata),
    .axis_in_tid        (in_tid),
    .axis_in_tdest      (in_tdest),
    .axis_in_tkeep      (in_tkeep),
    .axis_in_tlast      (in_tlast),
    .axis_in_tvalid     (in_tvalid),
    .axis_in_tready     (in_tready),
    .axis_out_tdata     (out_tdata),
    .axis_out_tid       (out_tid),
    .axis_out_tdest     (out_tdest),
    .axis_out_tkeep     (out_tkeep),
    .axis_out_tlast     (out_tlast),
    .axis_out_tvalid    (out_tvalid),
    .axis_out_tready    (out_tready),
    .route_mask_mac_in  (mac),
    .route_mask_vlan_in (vlan),
    .parsing_done_in    (pd_in),
    .cur_pos_in         (pos_in),
    .is_tagged_in       (tag_in),
    .parsed_etype       (petype),
    .parsed_etype_valid (pvalid),
    .route_mask_out     (route_out),
    .parsing_done_out   (pd_out),
    .cur_pos_out        (pos_out),
    .is_tagged_out      (tag_out),
    .etype_hit          (hit),
    .etype_hit_idx      (hit_idx),
    .cam_wr_en          (wr_en),
    .cam_wr_idx         (wr_idx),
    .cam_wr_etype       (wr_etype),
    .cam_wr_allow       (wr_allow),
    .cam_wr_bypass_mac  (wr_byp),
    .cam_wr_valid       (wr_valid),
    .allow_all_mask     (allow_all)
`ifdef ETYPE_CAM_STATS_EN
    ,
    .stats_rd_idx       (st_idx),
    .stats_rd_count     (st_cnt),
    .stats_miss_count   (st_miss)
`endif
  );

  always #5 aclk = ~aclk;

  int compared = 0;
  int mismatched = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] etype;
    logic [15:0] allow;
    logic        bypass;
    logic        valid;
  } m_entry_t;

  m_entry_t    m_cam [N_ENT];
  bit          m_held;
  logic        m_hit_h;
  logic [1:0]  m_idx_h;
  logic [15:0] m_emask_h;
  logic        m_byp_h;
  logic [31:0] m_cnt [N_ENT];
  logic [31:0] m_miss;

  // last observed DUT values, for directed spot checks
  logic        obs_hit;
  logic [1:0]  obs_idx;
  logic [15:0] obs_route;
  logic [31:0] obs_cnt, obs_miss;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_ENT; i++) begin
      m_cam[i] = '{16'h0, 16'h0, 1'b0, 1'b0};
      m_cnt[i] = 32'd0;
    end
    m_held = 0;
    m_miss = 32'd0;
  endtask

  // Lowest-numbered valid entry holding the key, if any.
  task automatic lookup(input logic [15:0] key, output logic h, output logic [1:0] ix);
    h  = 1'b0;
    ix = 2'd0;
    for (int i = 0; i < N_ENT; i++) begin
      if (m_cam[i].valid && m_cam[i].etype == key) begin
        h  = 1'b1;
        ix = 2'(i);
        break;
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    logic        e_hit, e_byp;
    logic [1:0]  e_idx;
    logic [15:0] e_emask, e_route;
    bit          acc, lastb;
    #5;
    e_hit = 1'b0; e_idx = 2'd0; e_emask = 16'hFFFF; e_byp = 1'b0;
    if (aresetn && m_held) begin
      e_hit = m_hit_h; e_idx = m_idx_h; e_emask = m_emask_h; e_byp = m_byp_h;
    end else if (aresetn && pvalid) begin
      lookup(petype, e_hit, e_idx);
      e_emask = allow_all | (e_hit ? m_cam[e_idx].allow : 16'h0);
      e_byp   = e_hit && m_cam[e_idx].bypass;
    end
    e_route = e_emask & vlan & (e_byp ? 16'hFFFF : mac);
    obs_hit = hit; obs_idx = hit_idx; obs_route = route_out;
    check("hit", hit, e_hit);
    check("idx", hit_idx, e_idx);
    check("route", route_out, e_route);
    check("tdata", out_tdata, in_tdata);
    check("side", {in_tready, out_tid, out_tdest, out_tkeep, out_tlast, out_tvalid, pd_out, pos_out, tag_out},
                  {out_tready, in_tid, in_tdest, in_tkeep, in_tlast, in_tvalid, pd_in, pos_in, tag_in});
`ifdef ETYPE_CAM_STATS_EN
    obs_cnt = st_cnt; obs_miss = st_miss;
    check("stat_cnt", st_cnt, m_cnt[st_idx]);
    check("stat_miss", st_miss, m_miss);
`endif
    acc   = aresetn && !m_held && pvalid;
    lastb = in_tvalid && out_tready && in_tlast;
    @(posedge aclk);
    if (aresetn) begin
      if (acc) begin
        if (e_hit) begin
          if (m_cnt[e_idx] != 32'hFFFF_FFFF) m_cnt[e_idx] = m_cnt[e_idx] + 1;
        end else if (m_miss != 32'hFFFF_FFFF) begin
          m_miss = m_miss + 1;
        end
      end
      if (lastb) m_held = 0;
      else if (acc) begin
        m_held = 1; m_hit_h = e_hit; m_idx_h = e_idx; m_emask_h = e_emask; m_byp_h = e_byp;
      end
      if (wr_en) begin
        m_cam[wr_idx] = '{wr_etype, wr_allow, wr_byp, wr_valid};
        m_cnt[wr_idx] = 32'd0;
      end
    end
    #1;
  endtask

  task automatic beat(input bit last, input bit pv, input logic [15:0] et);
    in_tvalid = 1'b1; in_tlast = last; pvalid = pv; petype = et;
    in_tdata = {$urandom, $urandom}; in_tid = 4'($urandom); in_tdest = 4'($urandom);
    in_tkeep = 8'($urandom); pd_in = 1'($urandom); pos_in = 11'($urandom); tag_in = 1'($urandom);
    step();
    pvalid = 1'b0;
  endtask

  task automatic idle();
    in_tvalid = 1'b0; in_tlast = 1'b0; pvalid = 1'b0;
    step();
  endtask

  task automatic cam_write(input logic [1:0] ix, input logic [15:0] et, input logic [15:0] al,
                           input logic byp, input logic vld);
    wr_en = 1'b1; wr_idx = ix; wr_etype = et; wr_allow = al; wr_byp = byp; wr_valid = vld;
    idle();
    wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    aresetn = 1'b0;
    model_clear();
    idle();
    idle();
    #2;
    aresetn = 1'b1;
  endtask

  function automatic logic [15:0] pick_etype();
    logic [15:0] pool [4];
    pool[0] = 16'h0008; pool[1] = 16'h0608; pool[2] = 16'hDD86; pool[3] = 16'h0081;
    if ($urandom_range(0, 4) == 4) return 16'($urandom);
    return pool[$urandom_range(0, 3)];
  endfunction

  initial begin
    model_clear();
    in_tdata = '0; in_tid = '0; in_tdest = '0; in_tkeep = '0; in_tlast = 0; in_tvalid = 0;
    out_tready = 1'b1; pd_in = 0; pos_in = '0; tag_in = 0;
    wr_en = 0; wr_idx = 0; wr_etype = 0; wr_allow = 0; wr_byp = 0; wr_valid = 0; allow_all = 16'h0;
`ifdef ETYPE_CAM_STATS_EN
    st_idx = 2'd0;
`endif
    // Reset held: outputs neutral even with a valid etype presented.
    mac = 16'h00F0; vlan = 16'h0FF0; pvalid = 1'b1; petype = 16'h0008;
    #1;
    step();
    check("rst_hit", obs_hit, 1'b0);
    check("rst_route", obs_route, 16'h00F0);
    step();
    #2;
    aresetn = 1'b1;
    pvalid = 1'b0;

    // Program CAM
    cam_write(2'd0, 16'h0008, 16'h0003, 1'b0, 1'b1);
    cam_write(2'd1, 16'h0608, 16'h0004, 1'b1, 1'b1);

    // Basic hit held for the whole packet
    mac = 16'hFFFF; vlan = 16'hFFFF;
    beat(0, 1, 16'h0008);
    check("r25_hit", obs_hit, 1'b1);
    check("r25_idx", obs_idx, 2'd0);
    check("r25_route", obs_route, 16'h0003);
    beat(0, 0, 16'h0608);
    beat(1, 0, 16'h0);
    check("r25_held_route", obs_route, 16'h0003);
    idle();

    // Bypass of MAC mask
    mac = 16'h0000;
    beat(0, 1, 16'h0608);
    check("r26_route", obs_route, 16'h0004);
    beat(1, 0, 16'h0);
    check("r26_held_route", obs_route, 16'h0004);

    // Duplicate entries resolve to lowest index; allow_all on a miss
    mac = 16'hFFFF;
    cam_write(2'd1, 16'h86DD, 16'h0100, 1'b0, 1'b1);
    cam_write(2'd2, 16'h86DD, 16'h0200, 1'b0, 1'b1);
    beat(1, 1, 16'h86DD);
    check("r27_idx", obs_idx, 2'd1);
    check("r27_route", obs_route, 16'h0100);
    allow_all = 16'h8000;
    beat(0, 1, 16'h1234);
    check("r27_miss_hit", obs_hit, 1'b0);
    check("r27_miss_route", obs_route, 16'h8000);
    beat(1, 0, 16'h0);
    allow_all = 16'h0000;

    // Etype valid on the last beat, then a new packet before its etype
    beat(1, 1, 16'h0008);
    check("r28_hit", obs_hit, 1'b1);
    check("r28_route", obs_route, 16'h0003);
    mac = 16'h0F0F; vlan = 16'h00FF;
    beat(0, 0, 16'h0008);
    check("r28_next_hit", obs_hit, 1'b0);
    check("r28_next_route", obs_route, 16'h000F);
    beat(1, 0, 16'h0);

    // Rewrite held entry mid-packet; second etype pulse in HOLD ignored
    mac = 16'hFFFF; vlan = 16'hFFFF;
    beat(0, 1, 16'h0008);
    wr_en = 1'b1; wr_idx = 2'd0; wr_etype = 16'h0008; wr_allow = 16'h0040; wr_byp = 1'b0; wr_valid = 1'b1;
    beat(0, 1, 16'h0608);
    wr_en = 1'b0;
    check("r29_hold_route", obs_route, 16'h0003);
    beat(1, 0, 16'h0);
    check("r29_last_route", obs_route, 16'h0003);
    beat(1, 1, 16'h0008);
    check("r29_new_route", obs_route, 16'h0040);

    // Reset in the middle of a packet drops the held result
    beat(0, 1, 16'h0008);
    check("rst_mid_pre_hit", obs_hit, 1'b1);
    apply_reset();
    mac = 16'h3C3C; vlan = 16'h0FF0;
    beat(0, 0, 16'h0);
    check("rst_mid_hit", obs_hit, 1'b0);
    check("rst_mid_route", obs_route, 16'h0C30);
    beat(1, 0, 16'h0);

`ifdef ETYPE_CAM_STATS_EN
    // Three matching packets (with a repeated pulse) and one unknown
    cam_write(2'd0, 16'h0008, 16'h0003, 1'b0, 1'b1);
    st_idx = 2'd0;
    for (int p = 0; p < 3; p++) begin
      beat(0, 1, 16'h0008);
      beat(0, 1, 16'h0008);
      beat(1, 0, 16'h0);
    end
    beat(1, 1, 16'h5555);
    idle();
    check("r30_cnt0", obs_cnt, 32'd3);
    check("r30_miss", obs_miss, 32'd1);
`endif

    // Randomized traffic
    for (int k = 0; k < N_ENT; k++) cam_write(2'(k), pick_etype(), 16'($urandom), 1'($urandom), 1'b1);
    for (int n = 0; n < 600; n++) begin
      if (n == 300) apply_reset();
      out_tready = ($urandom_range(0, 3) != 0);
      mac        = 16'($urandom);
      vlan       = 16'($urandom);
      allow_all  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      wr_en      = ($urandom_range(0, 15) == 0);
      wr_idx     = 2'($urandom); wr_etype = pick_etype(); wr_allow = 16'($urandom);
      wr_byp     = 1'($urandom); wr_valid = ($urandom_range(0, 4) != 0);
`ifdef ETYPE_CAM_STATS_EN
      st_idx     = 2'($urandom);
`endif
      if ($urandom_range(0, 3) == 0) begin
        in_tvalid = 1'b0; in_tlast = 1'($urandom); pvalid = ($urandom_range(0, 2) == 0);
        petype = pick_etype();
        step();
      end else begin
        beat(($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), pick_etype());
      end
      wr_en = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_etype_cam_filter
